// File: rtl/emu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// emu_ctrl_pkg
// Shared types for the emulation run controller:
//   op_t     - host command opcodes (3 bits; values 5..7 are illegal)
//   state_t  - controller states
//   cause_t  - reason the last operation completed (2 bits)
// -----------------------------------------------------------------------------
package emu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_RESET    = 3'd1,
      OP_RUN_N    = 3'd2,
      OP_RUN_FREE = 3'd3,
      OP_STOP     = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      ST_MRST,
      ST_IDLE,
      ST_RUN_CNT,
      ST_RUN_FREE
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_COUNT = 2'd1,
      CAUSE_STOP  = 2'd2,
      CAUSE_TRIG  = 2'd3
   } cause_t;

endpackage

// File: rtl/emu_step_ctrl.sv
// -----------------------------------------------------------------------------
// emu_step_ctrl
// Run controller for the emulated analog model. Drives the model step enable
// (go of the single-step clock generator) and the model reset, accepts host
// commands over a valid/ready handshake, counts emulated steps and stops on an
// external trigger from the model.
//
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   cmd_valid_i      - command valid
//   cmd_ready_o      - command ready (low only while the model is in reset)
//   cmd_op_i         - opcode (see op_t), cmd_n_i - step count for RUN_N
//   trig_i           - stop request from the model (only honoured while running)
//   emu_en_o         - model step enable
//   emu_rst_o        - model reset
//   busy_o           - controller not idle
//   done_o           - one-cycle pulse when an operation completes
//   cmd_err_o        - one-cycle pulse on an illegal or dropped command
//   stop_cause_o     - completion reason, updated with done_o
//   steps_left_o     - remaining steps of a RUN_N
//   time_o           - enabled steps since the last model reset
// All outputs are registered.
// -----------------------------------------------------------------------------
module emu_step_ctrl
   import emu_ctrl_pkg::*;
#(
   parameter int N_STEP_W  = 32,
   parameter int TIME_W    = 48,
   parameter int N_RST_CYC = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [2:0]          cmd_op_i,
   input  logic [N_STEP_W-1:0] cmd_n_i,
   input  logic                trig_i,
   output logic                emu_en_o,
   output logic                emu_rst_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                cmd_err_o,
   output logic [1:0]          stop_cause_o,
   output logic [N_STEP_W-1:0] steps_left_o,
   output logic [TIME_W-1:0]   time_o
);

   localparam int RCW = (N_RST_CYC > 1) ? $clog2(N_RST_CYC) : 1;
   // The counter is loaded with N_RST_CYC-1 and MRST exits on the cycle it
   // reads zero, so emu_rst_o is high for exactly N_RST_CYC cycles.
   localparam logic [RCW-1:0] RST_LOAD = RCW'(N_RST_CYC - 1);

   state_t         state;
   logic [RCW-1:0] rst_cnt;
   logic           rst_by_cmd;   // MRST entered via the RESET command

   logic accept;
   logic stop_cmd;
   logic trig_hit;
   logic last_step;
   logic drop_cmd;

   assign accept    = cmd_valid_i & cmd_ready_o;
   assign stop_cmd  = accept && (cmd_op_i == OP_STOP);
   assign trig_hit  = trig_i && emu_en_o;
   assign last_step = (state == ST_RUN_CNT) && (steps_left_o == N_STEP_W'(1));
   // While running, anything other than NOP/STOP is accepted but discarded.
   assign drop_cmd  = accept && (cmd_op_i != OP_NOP) && (cmd_op_i != OP_STOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_MRST;
         rst_cnt      <= RST_LOAD;
         rst_by_cmd   <= 1'b0;
         emu_rst_o    <= 1'b1;
         emu_en_o     <= 1'b0;
         cmd_ready_o  <= 1'b0;
         busy_o       <= 1'b1;
         done_o       <= 1'b0;
         cmd_err_o    <= 1'b0;
         stop_cause_o <= CAUSE_NONE;
         steps_left_o <= '0;
         time_o       <= '0;
      end else begin
         done_o    <= 1'b0;
         cmd_err_o <= 1'b0;
         // Counts the cycle being left; entering MRST below overrides it.
         if (emu_en_o) time_o <= time_o + TIME_W'(1);

         case (state)
            ST_MRST: begin
               if (rst_cnt == '0) begin
                  state       <= ST_IDLE;
                  emu_rst_o   <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
                  // Only a host-requested reset reports completion.
                  if (rst_by_cmd) begin
                     done_o       <= 1'b1;
                     stop_cause_o <= CAUSE_NONE;
                  end
               end else begin
                  rst_cnt <= rst_cnt - RCW'(1);
               end
            end

            ST_IDLE: begin
               if (accept) begin
                  case (cmd_op_i)
                     OP_RESET: begin
                        state       <= ST_MRST;
                        rst_cnt     <= RST_LOAD;
                        rst_by_cmd  <= 1'b1;
                        emu_rst_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        time_o      <= '0;
                     end
                     OP_RUN_N: begin
                        if (cmd_n_i == '0) begin
                           done_o       <= 1'b1;
                           stop_cause_o <= CAUSE_COUNT;
                        end else begin
                           state        <= ST_RUN_CNT;
                           emu_en_o     <= 1'b1;
                           busy_o       <= 1'b1;
                           steps_left_o <= cmd_n_i;
                        end
                     end
                     OP_RUN_FREE: begin
                        state        <= ST_RUN_FREE;
                        emu_en_o     <= 1'b1;
                        busy_o       <= 1'b1;
                        steps_left_o <= '0;
                     end
                     OP_NOP, OP_STOP: ;
                     default: cmd_err_o <= 1'b1;
                  endcase
               end
            end

            ST_RUN_CNT, ST_RUN_FREE: begin
               if (drop_cmd) cmd_err_o <= 1'b1;
               if (trig_hit || stop_cmd || last_step) begin
                  state    <= ST_IDLE;
                  emu_en_o <= 1'b0;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  // Priority TRIG > STOP > COUNT; only a count completion
                  // clears steps_left, the others freeze it.
                  if (trig_hit) begin
                     stop_cause_o <= CAUSE_TRIG;
                  end else if (stop_cmd) begin
                     stop_cause_o <= CAUSE_STOP;
                  end else begin
                     stop_cause_o <= CAUSE_COUNT;
                     steps_left_o <= '0;
                  end
               end else if (state == ST_RUN_CNT) begin
                  steps_left_o <= steps_left_o - N_STEP_W'(1);
               end
            end

            default: state <= ST_MRST;
         endcase
      end
   end

endmodule

// File: tb/tb_emu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_emu_step_ctrl
// Scoreboard bench for emu_step_ctrl. The driver computes, from the operation
// it is about to issue, when and why it must finish and what the step counter
// must read; those expectations are queued. A monitor pops one expectation per
// done/err pulse. A second instance with a 4-bit time counter sees the same
// stimulus and must read the low 4 bits of the expected time.
// -----------------------------------------------------------------------------
module tb_emu_step_ctrl;
   import emu_ctrl_pkg::*;

   localparam int NSW = 32;
   localparam int TW  = 48;
   localparam int NRC = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cmd_valid = 1'b0;
   logic [2:0]     cmd_op = 3'd0;
   logic [NSW-1:0] cmd_n = '0;
   logic           trig = 1'b0;

   logic           cmd_ready_o, emu_en_o, emu_rst_o, busy_o, done_o, cmd_err_o;
   logic [1:0]     stop_cause_o;
   logic [NSW-1:0] steps_left_o;
   logic [TW-1:0]  time_o;

   logic           ready_4, en_4, erst_4, busy_4, done_4, err_4;
   logic [1:0]     cause_4;
   logic [NSW-1:0] sl_4;
   logic [3:0]     time_4;

   emu_step_ctrl #(.N_STEP_W(NSW), .TIME_W(TW), .N_RST_CYC(NRC)) dut (
      .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op), .cmd_n_i(cmd_n), .trig_i(trig), .emu_en_o(emu_en_o),
      .emu_rst_o(emu_rst_o), .busy_o(busy_o), .done_o(done_o), .cmd_err_o(cmd_err_o),
      .stop_cause_o(stop_cause_o), .steps_left_o(steps_left_o), .time_o(time_o)
   );

   emu_step_ctrl #(.N_STEP_W(NSW), .TIME_W(4), .N_RST_CYC(NRC)) dut4 (
      .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_4),
      .cmd_op_i(cmd_op), .cmd_n_i(cmd_n), .trig_i(trig), .emu_en_o(en_4),
      .emu_rst_o(erst_4), .busy_o(busy_4), .done_o(done_4), .cmd_err_o(err_4),
      .stop_cause_o(cause_4), .steps_left_o(sl_4), .time_o(time_4)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [1:0]  cause;
      logic [47:0] tm;
      logic [31:0] sl;
      bit          chk_sl;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [47:0] model_time = '0;

   task automatic check(input string name, input bit ok,
                        input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: one expectation per completion or error pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (done_o || cmd_err_o)) begin
            if (sb.size() == 0) begin
               check("unexpected_event", 1'b0, {done_o, cmd_err_o}, 0);
            end else begin
               e = sb.pop_front();
               if (e.is_err) begin
                  check("err_pulse", cmd_err_o && !done_o, {done_o, cmd_err_o}, 2'b01);
                  $display("txn err   cause=- time=%0d", time_o);
               end else begin
                  check("done_cause", done_o && !cmd_err_o && stop_cause_o == e.cause,
                        {done_o, cmd_err_o, stop_cause_o}, {2'b10, e.cause});
                  check("done_time", time_o == e.tm, time_o, e.tm);
                  check("wrap_time", time_4 == e.tm[3:0], time_4, e.tm[3:0]);
                  if (e.chk_sl) check("steps_left", steps_left_o == e.sl, steps_left_o, e.sl);
                  $display("txn done  cause=%0d time=%0d steps_left=%0d",
                           stop_cause_o, time_o, steps_left_o);
               end
            end
         end
      end
   end

   task automatic idle_cycle();
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      trig      = 1'b0;
   endtask

   // Presents a command and returns just after the edge that accepts it.
   task automatic send_cmd(input logic [2:0] op, input logic [31:0] n);
      int w;
      w = 0;
      @(negedge clk);
      while (!cmd_ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready_o) check("ready_timeout", 1'b0, 0, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_n     = n;
      trig      = 1'b0;
      @(posedge clk);
   endtask

   // Runs RUN_N n (or RUN_FREE) with optional trigger/STOP/dropped command on
   // enabled cycle numbers (1-based, 0 = none). The run ends on the earliest
   // event; equal cycles resolve TRIG > STOP > COUNT.
   task automatic do_run(input bit is_free, input int n, input int trig_at,
                         input int stop_at, input int drop_at, input logic [2:0] drop_op);
      int         c;
      logic [1:0] cause;
      exp_t       e;
      c     = is_free ? 32'h3fff_ffff : n;
      cause = CAUSE_COUNT;
      if (stop_at > 0 && stop_at <= c) begin c = stop_at; cause = CAUSE_STOP; end
      if (trig_at > 0 && trig_at <= c) begin c = trig_at; cause = CAUSE_TRIG; end
      if (drop_at > 0 && drop_at < c) begin
         e = '{1'b1, 2'd0, 48'd0, 32'd0, 1'b0};
         sb.push_back(e);
      end
      e.is_err = 1'b0;
      e.cause  = cause;
      e.tm     = model_time + 48'(c);
      e.sl     = (cause == CAUSE_COUNT) ? 32'd0 : 32'(n - c + 1);
      e.chk_sl = !is_free && n > 0;
      sb.push_back(e);
      model_time = e.tm;
      send_cmd(is_free ? OP_RUN_FREE : OP_RUN_N, 32'(n));
      for (int i = 1; i <= c; i++) begin
         @(negedge clk);
         trig = (i == trig_at);
         if (i == stop_at) begin
            cmd_valid = 1'b1; cmd_op = OP_STOP;
         end else if (i == drop_at && drop_at < c) begin
            cmd_valid = 1'b1; cmd_op = drop_op;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      idle_cycle();
   endtask

   task automatic do_reset_cmd();
      exp_t e;
      e = '{1'b0, CAUSE_NONE, 48'd0, 32'd0, 1'b0};
      sb.push_back(e);
      model_time = '0;
      send_cmd(OP_RESET, 32'd0);
      idle_cycle();
   endtask

   task automatic do_illegal(input logic [2:0] op);
      exp_t e;
      e = '{1'b1, 2'd0, 48'd0, 32'd0, 1'b0};
      sb.push_back(e);
      send_cmd(op, 32'd0);
      idle_cycle();
   endtask

   // NOP/STOP in IDLE plus a trigger pulse: nothing may be reported.
   task automatic do_noop(input logic [2:0] op);
      send_cmd(op, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      trig      = 1'b1;
      idle_cycle();
   endtask

   initial begin
      logic [2:0] drop_ops [6];
      int sel, n, ta, sa, da, len, mode, w;
      drop_ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

      // Reset for one edge, then watch the model-reset window.
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= NRC + 2; i++) begin
         if (i > 1) @(negedge clk);
         check("rst_window_emu_rst", emu_rst_o == (i <= NRC), emu_rst_o, 64'(i <= NRC));
         check("rst_window_ready", cmd_ready_o == (i > NRC), cmd_ready_o, 64'(i > NRC));
         check("rst_window_time", time_o == 0 && !done_o, {done_o, time_o}, 0);
         if (i == 1)
            check("reset_values",
                  {emu_en_o, busy_o, cmd_err_o, stop_cause_o} == 5'b01000 && steps_left_o == 0,
                  {emu_en_o, busy_o, cmd_err_o, stop_cause_o, steps_left_o},
                  {5'b01000, 32'd0});
      end

      // Directed scenarios.
      do_run(1'b0, 5, 0, 0, 0, 3'd0);
      do_run(1'b0, 0, 0, 0, 0, 3'd0);
      do_run(1'b1, 0, 10, 0, 0, 3'd0);
      do_run(1'b0, 100, 3, 3, 0, 3'd0);
      do_run(1'b1, 0, 0, 8, 4, OP_RUN_N);
      do_reset_cmd();
      do_run(1'b0, 17, 0, 0, 0, 3'd0);
      do_illegal(3'd6);
      do_noop(OP_STOP);

      // Randomized operations.
      for (int k = 0; k < 60; k++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3) begin
            n  = $urandom_range(0, 20);
            ta = $urandom_range(0, 1) ? $urandom_range(1, n + 2) : 0;
            sa = $urandom_range(0, 1) ? $urandom_range(1, n + 2) : 0;
            da = $urandom_range(0, 1) ? $urandom_range(1, n + 1) : 0;
            do_run(1'b0, n, ta, sa, da, drop_ops[$urandom_range(0, 5)]);
         end else if (sel <= 6) begin
            len  = $urandom_range(1, 25);
            mode = $urandom_range(0, 2);
            ta   = (mode != 1) ? len : 0;
            sa   = (mode == 1) ? len : ((mode == 2) ? $urandom_range(1, 25) : 0);
            da   = $urandom_range(0, 1) ? $urandom_range(1, 25) : 0;
            do_run(1'b1, 0, ta, sa, da, drop_ops[$urandom_range(0, 5)]);
         end else if (sel == 7) begin
            do_reset_cmd();
         end else if (sel == 8) begin
            do_illegal(3'($urandom_range(5, 7)));
         end else begin
            do_noop($urandom_range(0, 1) ? OP_NOP : OP_STOP);
         end
      end

      // Reset in the middle of a counted run: abort, no completion.
      send_cmd(OP_RUN_N, 32'd50);
      repeat (5) idle_cycle();
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrun_reset_values",
            {emu_en_o, emu_rst_o, cmd_ready_o, busy_o, done_o, cmd_err_o, stop_cause_o} == 8'b01010000
            && steps_left_o == 0 && time_o == 0,
            {emu_en_o, emu_rst_o, cmd_ready_o, busy_o, done_o, cmd_err_o, stop_cause_o, steps_left_o},
            {8'b01010000, 32'd0});
      check("midrun_reset_wrap_dut", !en_4 && erst_4 && time_4 == 0, {en_4, erst_4, time_4}, 6'b010000);
      rst = 1'b0;
      model_time = '0;
      do_run(1'b0, 3, 0, 0, 0, 3'd0);

      // Drain outstanding expectations.
      w = 0;
      while (sb.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", sb.size() == 0, sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/emu_step_ctrl.md
Name: emu_step_ctrl

Overview:
Run controller that sequences the emulated analog model. It produces the model's clock-enable (the go input of the single-step clock generator) and the model's reset. It accepts host commands over a valid/ready handshake: reset model, run N steps, run free, stop. It keeps a running count of emulated steps and stops on an external trigger from the model (e.g. a threshold crossing).

Parameters:
N_STEP_W, 32, width of the run-length operand and of the steps-remaining counter
TIME_W, 48, width of the emulated-step (time) counter
N_RST_CYC, 4, number of cycles emu_rst_o is held high per model reset (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_op_i  in  3  opcode: NOP=0, RESET=1, RUN_N=2, RUN_FREE=3, STOP=4; others illegal
cmd_n_i  in  N_STEP_W  step count for RUN_N
trig_i  in  1  stop request from model logic
emu_en_o  out  1  model step enable / go
emu_rst_o  out  1  model reset
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when an operation completes
cmd_err_o  out  1  one-cycle pulse on an illegal or dropped command
stop_cause_o  out  2  NONE=0, COUNT=1, STOP=2, TRIG=3; valid with done_o, held until next done_o
steps_left_o  out  N_STEP_W  remaining steps in RUN_N
time_o  out  TIME_W  total enabled steps since last model reset

Behaviour:
- All outputs are registered.
- States: MRST, IDLE, RUN_CNT, RUN_FREE.
- Reset values: state=MRST, emu_rst_o=1, emu_en_o=0, cmd_ready_o=0, busy_o=1, done_o=0, cmd_err_o=0, stop_cause_o=NONE, steps_left_o=0, time_o=0.
- Reset mid-operation: abort immediately, no done_o.
- MRST:
  - emu_rst_o=1, emu_en_o=0, time_o held at 0.
  - Lasts exactly N_RST_CYC cycles after rst deassert (or after RESET acceptance), then IDLE.
  - done_o pulses on the first IDLE cycle only when entered via the RESET command; the post-rst entry gives no done_o.
- Handshake: a command transfers on cycle t when cmd_valid_i & cmd_ready_o; its effect is visible at t+1.
  - cmd_ready_o=1 in IDLE, RUN_CNT and RUN_FREE; 0 in MRST.
- IDLE: RESET goes to MRST. RUN_N goes to RUN_CNT. RUN_FREE goes to RUN_FREE. STOP and NOP are no-ops.
  - RUN_N with n=0: stay IDLE, done_o at t+1, cause=COUNT.
  - Illegal opcode: cmd_err_o at t+1, no state change.
- RUN_CNT (RUN_N n accepted at t):
  - emu_en_o=1 on cycles t+1 .. t+n exactly.
  - steps_left_o=n at t+1, decrementing to 1 on the last enabled cycle.
  - Next cycle: IDLE, emu_en_o=0, steps_left_o=0, done_o=1, cause=COUNT.
- RUN_FREE: emu_en_o=1 every cycle until a stop event.
- Stop events while running, sampled in cycle c:
  - trig_i=1 while emu_en_o=1 -> TRIG.
  - Accepted STOP -> STOP.
  - Last count step -> COUNT.
  - Any stop event: emu_en_o=0 at c+1, state IDLE at c+1, done_o=1 at c+1.
  - Priority when simultaneous: TRIG > STOP > COUNT.
  - steps_left_o freezes at its value at c (0 for COUNT).
- In RUN states, RESET/RUN_N/RUN_FREE/illegal are accepted and dropped, with cmd_err_o at t+1.
- time_o:
  - Increments by 1 on every cycle emu_en_o=1; wraps modulo 2^TIME_W.
  - Cleared to 0 when entering MRST.
- trig_i in IDLE or MRST is ignored.

Decomposition:
- Package emu_ctrl_pkg: op_t enum (3 bits), state_t enum, cause_t enum (2 bits).
- Single module; no sub-module needed. Counters are inline.

Test Plan:
- rst 1 cycle then release -> emu_rst_o high for exactly 4 cycles, cmd_ready_o rises on cycle 5, no done_o, time_o=0.
- RUN_N n=5 accepted at t -> emu_en_o high t+1..t+5, time_o=5, done_o at t+6 with cause=COUNT; then RUN_N n=0 -> done_o next cycle, time_o unchanged.
- RUN_FREE, trig_i pulsed on the 10th enabled cycle -> emu_en_o low next cycle, time_o=10, cause=TRIG.
- RUN_N n=100; on the 3rd enabled cycle issue STOP with trig_i=1 simultaneously -> cause=TRIG, steps_left_o=98, time_o=3.
- During RUN_FREE issue RUN_N -> cmd_err_o pulse, run continues. Then STOP -> cause=STOP. Then RESET -> time_o=0, emu_rst_o 4 cycles, done_o.
- Assert rst mid-RUN_CNT -> emu_en_o=0 and all outputs at reset values next cycle, no done_o. Also preload TIME_W=4 and run 17 steps -> time_o=1 (wrap).
